sensor_access_arbiter: RTL and testbench

- Shares the single sensor decoder between NUM_REQ independent requesters (UART command parser, debug console, future clients).
- Grants round-robin, sequences the decoder's enable/finished handshake, enforces the minimum DHT11 re-read interval and times out a hung decoder.
- Returns each response tagged with the requester's ID.
- Sits between the requester front-ends and the sensor decoder.

---
 rtl/sensor_access_arbiter_if.sv | 36 +++
 rtl/sensor_access_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_sensor_access_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_access_arbiter_if.sv
// sensor_access_arbiter_if: requester-side and decoder-side signals of the sensor access arbiter.
// The arbiter connects through the slave modport; the environment (requesters plus decoder) uses master.
interface sensor_access_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   // requester side
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_command;
   logic [5*NUM_REQ-1:0] req_device;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic [2:0]           rsp_id;
   logic [7:0]           rsp_code;
   logic [7:0]           rsp_data;
   // decoder side
   logic                 dec_enable;
   logic [7:0]           dec_request;
   logic [31:0]          dec_device_selector;
   logic [7:0]           dec_response;
   logic [7:0]           dec_response_code;
   logic                 dec_finished;

   modport slave (
      input  req_valid, req_command, req_device,
      output req_ready, rsp_valid, rsp_id, rsp_code, rsp_data,
      output dec_enable, dec_request, dec_device_selector,
      input  dec_response, dec_response_code, dec_finished
   );

   modport master (
      output req_valid, req_command, req_device,
      input  req_ready, rsp_valid, rsp_id, rsp_code, rsp_data,
      input  dec_enable, dec_request, dec_device_selector,
      output dec_response, dec_response_code, dec_finished
   );
endinterface

// File: rtl/sensor_access_arbiter.sv
// sensor_access_arbiter: round-robin sharing of the single sensor decoder between NUM_REQ requesters.
// Sequences the decoder enable/finished handshake, enforces a MIN_GAP idle window between decoder
// transactions, times out a hung decoder after TIMEOUT cycles and tags each response with the requester id.
// Optional feature macro: SENSOR_MONITOR_EN (local subscribe/unsubscribe commands 0x03..0x06 and
// periodic internal polls); without it every command is forwarded to the decoder verbatim.
module sensor_access_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned NUM_DEVICES    = 1,
   parameter int unsigned MIN_GAP        = 50000000,
   parameter int unsigned TIMEOUT        = 150000000,
   parameter int unsigned MONITOR_PERIOD = 100000000
) (
   input  logic                  clock,
   input  logic                  reset,
   sensor_access_arbiter_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER, S_GUARD} state_t;

   localparam logic [31:0] GAP_LAST  = (MIN_GAP > 0) ? 32'(MIN_GAP - 1) : 32'd0;
   localparam logic [31:0] WAIT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
   localparam logic [31:0] CNT_MAX   = '1;
   localparam logic [2:0]  LAST_REQ  = 3'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [7:0]         cmd_q, cmd_d;            // command of the transaction in flight
   logic [4:0]         dev_q, dev_d;            // device index of the transaction in flight
   logic [2:0]         grant_q, grant_d;        // last granted requester, also the response id
   logic [7:0]         code_q, code_d;
   logic [7:0]         data_q, data_d;
   logic               dec_used_q, dec_used_d;  // transaction touched the decoder -> GUARD follows
   logic [31:0]        wait_cnt_q, wait_cnt_d;
   logic [31:0]        gap_cnt_q, gap_cnt_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;

   // per-requester views of the packed request buses, padded to 8 entries so a 3-bit id indexes them
   logic [7:0] req_cmd [8];
   logic [4:0] req_dev [8];

   // arbitration result for the current IDLE cycle
   logic [3:0] ext_pick;
   logic       take;
   logic       take_ext;
   logic [2:0] take_idx;
   logic [7:0] take_cmd;
   logic [4:0] take_dev;

`ifdef SENSOR_MONITOR_EN
   localparam logic [31:0] PERIOD_LAST = (MONITOR_PERIOD > 0) ? 32'(MONITOR_PERIOD - 1) : 32'd0;

   logic [7:0]  temp_sub_q, temp_sub_d;
   logic [7:0]  hum_sub_q, hum_sub_d;
   logic [7:0]  poll_pend_q, poll_pend_d;
   logic [7:0]  alt_q, alt_d;               // next poll is humidity when both bits are set
   logic [31:0] period_cnt_q [8];
   logic [31:0] period_cnt_d [8];
   logic [7:0]  poll_cmd_q [8];
   logic [7:0]  poll_cmd_d [8];
   logic [4:0]  mon_dev_q [8];
   logic [4:0]  mon_dev_d [8];
   logic [3:0]  poll_pick;
`endif

   // first set bit at or after (last + 1) mod NUM_REQ; returns {found, index}
   function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] pend, input logic [2:0] last);
      logic [7:0] pend8;
      logic [3:0] res;
      int         idx;
      pend8 = 8'(pend);
      res   = '0;
      for (int k = int'(NUM_REQ); k >= 1; k--) begin
         idx = (int'(last) + k) % int'(NUM_REQ);
         if (pend8[3'(idx)]) res = {1'b1, 3'(idx)};
      end
      return res;
   endfunction

   // unpack the per-requester command and device fields
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         req_cmd[i] = '0;
         req_dev[i] = '0;
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         req_cmd[i] = bus.req_command[8*i +: 8];
         req_dev[i] = bus.req_device[5*i +: 5];
      end
   end

   // round-robin choice: external requests first, internal polls only when no request is pending
   always_comb begin
      ext_pick = rr_pick(bus.req_valid, grant_q);
      take     = ext_pick[3];
      take_ext = ext_pick[3];
      take_idx = ext_pick[2:0];
      take_cmd = req_cmd[ext_pick[2:0]];
      take_dev = req_dev[ext_pick[2:0]];
`ifdef SENSOR_MONITOR_EN
      poll_pick = rr_pick(poll_pend_q[NUM_REQ-1:0], grant_q);
      if (!ext_pick[3] && poll_pick[3]) begin
         take     = 1'b1;
         take_ext = 1'b0;
         take_idx = poll_pick[2:0];
         take_cmd = poll_cmd_q[poll_pick[2:0]];
         take_dev = mon_dev_q[poll_pick[2:0]];
      end
`endif
   end

   // state register and datapath flops
   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         dev_q      <= '0;
         grant_q    <= LAST_REQ;
         code_q     <= '0;
         data_q     <= '0;
         dec_used_q <= 1'b0;
         wait_cnt_q <= '0;
         gap_cnt_q  <= '0;
         ready_q    <= '0;
`ifdef SENSOR_MONITOR_EN
         temp_sub_q  <= '0;
         hum_sub_q   <= '0;
         poll_pend_q <= '0;
         alt_q       <= '0;
         // NOTE: these small tables are reset on purpose: a subscription or pending poll must not survive reset.
         for (int i = 0; i < 8; i++) begin
            period_cnt_q[i] <= '0;
            poll_cmd_q[i]   <= '0;
            mon_dev_q[i]    <= '0;
         end
`endif
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         dev_q      <= dev_d;
         grant_q    <= grant_d;
         code_q     <= code_d;
         data_q     <= data_d;
         dec_used_q <= dec_used_d;
         wait_cnt_q <= wait_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         ready_q    <= ready_d;
`ifdef SENSOR_MONITOR_EN
         temp_sub_q  <= temp_sub_d;
         hum_sub_q   <= hum_sub_d;
         poll_pend_q <= poll_pend_d;
         alt_q       <= alt_d;
         for (int i = 0; i < 8; i++) begin
            period_cnt_q[i] <= period_cnt_d[i];
            poll_cmd_q[i]   <= poll_cmd_d[i];
            mon_dev_q[i]    <= mon_dev_d[i];
         end
`endif
      end
   end

   // next-state and datapath update
   // NOTE: every _d starts as a copy of its _q, so no branch can leave a variable unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      dev_d      = dev_q;
      grant_d    = grant_q;
      code_d     = code_q;
      data_d     = data_q;
      dec_used_d = dec_used_q;
      wait_cnt_d = wait_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      ready_d    = '0;
`ifdef SENSOR_MONITOR_EN
      temp_sub_d   = temp_sub_q;
      hum_sub_d    = hum_sub_q;
      poll_pend_d  = poll_pend_q;
      alt_d        = alt_q;
      period_cnt_d = period_cnt_q;
      poll_cmd_d   = poll_cmd_q;
      mon_dev_d    = mon_dev_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (take) begin
               grant_d = take_idx;
               cmd_d   = take_cmd;
               dev_d   = take_dev;
               if (take_ext) ready_d = NUM_REQ'(1) << take_idx;
`ifdef SENSOR_MONITOR_EN
               if (!take_ext) poll_pend_d[take_idx] = 1'b0;
               if (take_ext && (take_cmd inside {8'h03, 8'h04, 8'h05, 8'h06})) begin
                  state_d    = S_DELIVER;
                  dec_used_d = 1'b0;
                  data_d     = 8'hCA;
                  case (take_cmd)
                     8'h03: begin
                        temp_sub_d[take_idx] = 1'b1;
                        mon_dev_d[take_idx]  = take_dev;
                        code_d               = 8'h15;
                     end
                     8'h04: begin
                        hum_sub_d[take_idx] = 1'b1;
                        mon_dev_d[take_idx] = take_dev;
                        code_d              = 8'h16;
                     end
                     8'h05: begin
                        if (!temp_sub_q[take_idx]) data_d = 8'hEA;
                        temp_sub_d[take_idx] = 1'b0;
                        code_d               = 8'h17;
                     end
                     default: begin
                        if (!hum_sub_q[take_idx]) data_d = 8'hEA;
                        hum_sub_d[take_idx] = 1'b0;
                        code_d              = 8'h18;
                     end
                  endcase
               end else
`endif
               if (32'(take_dev) >= NUM_DEVICES) begin
                  // unknown device: answer locally, the decoder never sees it
                  state_d    = S_DELIVER;
                  dec_used_d = 1'b0;
                  code_d     = 8'hED;
                  data_d     = 8'hED;
               end else begin
                  state_d    = S_ISSUE;
                  dec_used_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
         end
         S_WAIT: begin
            // a finish in the timeout cycle takes priority over the timeout
            if (bus.dec_finished) begin
               state_d = S_DELIVER;
               code_d  = bus.dec_response_code;
               data_d  = bus.dec_response;
            end else if (wait_cnt_q >= WAIT_LAST) begin
               state_d = S_DELIVER;
               code_d  = 8'hEF;
               data_d  = 8'hEE;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
         end
         S_DELIVER: begin
            if (dec_used_q) begin
               state_d   = S_GUARD;
               gap_cnt_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GUARD: begin
            if (gap_cnt_q >= GAP_LAST) state_d = S_IDLE;
            else if (gap_cnt_q != CNT_MAX) gap_cnt_d = gap_cnt_q + 32'd1;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef SENSOR_MONITOR_EN
      // per-requester poll timers run only while a subscription bit is set
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!(temp_sub_d[i] || hum_sub_d[i])) begin
            period_cnt_d[i] = '0;
            poll_pend_d[i]  = 1'b0;
         end else if (period_cnt_q[i] >= PERIOD_LAST) begin
            period_cnt_d[i] = '0;
            if (!poll_pend_q[i]) begin
               poll_pend_d[i] = 1'b1;
               if (temp_sub_d[i] && hum_sub_d[i]) begin
                  poll_cmd_d[i] = alt_q[i] ? 8'h02 : 8'h01;
                  alt_d[i]      = ~alt_q[i];
               end else begin
                  poll_cmd_d[i] = temp_sub_d[i] ? 8'h01 : 8'h02;
               end
            end
         end else begin
            period_cnt_d[i] = period_cnt_q[i] + 32'd1;
         end
      end
`endif
   end

   // Moore outputs decoded from the registered state
   always_comb begin
      bus.req_ready           = ready_q;
      bus.rsp_valid           = (state_q == S_DELIVER);
      bus.rsp_id              = (state_q == S_DELIVER) ? grant_q : 3'd0;
      bus.rsp_code            = (state_q == S_DELIVER) ? code_q : 8'd0;
      bus.rsp_data            = (state_q == S_DELIVER) ? data_q : 8'd0;
      bus.dec_enable          = (state_q == S_WAIT);
      bus.dec_request         = (state_q == S_ISSUE || state_q == S_WAIT) ? cmd_q : 8'd0;
      bus.dec_device_selector = (state_q == S_ISSUE || state_q == S_WAIT) ? (32'd1 << dev_q) : 32'd0;
   end
endmodule

// File: tb/tb_sensor_access_arbiter.sv
// tb_sensor_access_arbiter: directed checks of grant order, decoder handshake, guard gap,
// timeout, invalid device and mid-transaction reset, with a stub decoder of programmable latency.
module tb_sensor_access_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   sensor_access_arbiter_if #(.NUM_REQ(4)) bus ();

   sensor_access_arbiter #(
      .NUM_REQ(4), .NUM_DEVICES(1), .MIN_GAP(4), .TIMEOUT(20), .MONITOR_PERIOD(50)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // stub decoder: finishes stub_delay enabled cycles after dec_enable rises; 0 means never
   int         stub_delay = 10;
   int         stub_cnt   = 0;
   bit         stub_done  = 1'b0;
   logic [7:0] stub_code  = 8'h13;
   logic [7:0] stub_data  = 8'h19;

   always @(negedge clock) begin
      if (bus.dec_enable && !stub_done) begin
         stub_cnt++;
         if (stub_delay != 0 && stub_cnt == stub_delay) begin
            bus.dec_finished      = 1'b1;
            bus.dec_response_code = stub_code;
            bus.dec_response      = stub_data;
            stub_done             = 1'b1;
         end
      end else begin
         bus.dec_finished = 1'b0;
         if (!bus.dec_enable) begin
            stub_cnt  = 0;
            stub_done = 1'b0;
         end
      end
   end

   // event logs filled at every sampled negedge
   int          grant_log[$];
   int          grant_cyc[$];
   logic [18:0] rsp_log[$];
   int          last_rsp_cyc = 0;
   int          en_rise = 0;
   int          en_fall = 0;
   bit          en_prev = 1'b0;
   bit          en_seen = 1'b0;
   logic [7:0]  req_at_rise = '0;
   logic [31:0] sel_at_rise = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance to the next negedge, log outputs and let requesters drop valid on ready
   task automatic step();
      @(negedge clock);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (bus.req_ready[i]) begin
            grant_log.push_back(i);
            grant_cyc.push_back(cyc);
            bus.req_valid[i] = 1'b0;
         end
      end
      if (bus.rsp_valid) begin
         rsp_log.push_back({bus.rsp_id, bus.rsp_code, bus.rsp_data});
         last_rsp_cyc = cyc;
      end
      if (bus.dec_enable && !en_prev) begin
         en_rise     = cyc;
         req_at_rise = bus.dec_request;
         sel_at_rise = bus.dec_device_selector;
      end
      if (!bus.dec_enable && en_prev) en_fall = cyc;
      if (bus.dec_enable) en_seen = 1'b1;
      en_prev = bus.dec_enable;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clear_logs();
      grant_log.delete();
      grant_cyc.delete();
      rsp_log.delete();
      en_seen = 1'b0;
   endtask

   task automatic raise(input int i, input logic [7:0] cmd, input logic [4:0] dev);
      bus.req_command[8*i +: 8] = cmd;
      bus.req_device[5*i +: 5]  = dev;
      bus.req_valid[i]          = 1'b1;
   endtask

   task automatic wait_rsp(input int n, input int budget, input string tag);
      int k = 0;
      while (rsp_log.size() < n && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(rsp_log.size()), 32'(n));
   endtask

   task automatic wait_grant(input int n, input int budget, input string tag);
      int k = 0;
      while (grant_log.size() < n && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(grant_log.size()), 32'(n));
   endtask

   function automatic logic [31:0] grant_at(input int k);
      return (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] gcyc_at(input int k);
      return (k < grant_cyc.size()) ? 32'(grant_cyc[k]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] rsp_at(input int k);
      return (k < rsp_log.size()) ? 32'(rsp_log[k]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] rsp_exp(input logic [2:0] id, input logic [7:0] code, input logic [7:0] data);
      return 32'({id, code, data});
   endfunction

   initial begin
      int r;
      int order[6];
      order = '{0, 1, 2, 3, 0, 2};
      bus.req_valid   = '0;
      bus.req_command = '0;
      bus.req_device  = '0;

      // reset state: every output low
      reset = 1'b1;
      run(2);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_fields", {13'd0, bus.rsp_id, bus.rsp_code, bus.rsp_data}, 32'h0);
      check("rst_dec_enable", 32'(bus.dec_enable), 32'h0);
      check("rst_dec_request", 32'(bus.dec_request), 32'h0);
      check("rst_dec_selector", bus.dec_device_selector, 32'h0);
      reset = 1'b0;
      run(1);

      // single request from requester 1, decoder answers after 10 cycles
      clear_logs();
      stub_delay = 10;
      raise(1, 8'h01, 5'd0);
      wait_rsp(1, 100, "single_rsp_count");
      check("single_grant_id", grant_at(0), 32'd1);
      check("single_ready_pulses", 32'(grant_log.size()), 32'd1);
      check("single_enable_latency", 32'(en_rise) - gcyc_at(0), 32'd1);
      check("single_dec_request", 32'(req_at_rise), 32'h01);
      check("single_dec_selector", sel_at_rise, 32'h1);
      check("single_rsp", rsp_at(0), rsp_exp(3'd1, 8'h13, 8'h19));
      // requester 0 raises during DELIVER: DELIVER, 4 GUARD cycles, IDLE, then the ready cycle
      r = last_rsp_cyc;
      raise(0, 8'h02, 5'd0);
      wait_grant(2, 50, "guard_grant_count");
      check("guard_grant_id", grant_at(1), 32'd0);
      check("guard_gap_cycles", gcyc_at(1) - 32'(r), 32'd6);
      wait_rsp(2, 100, "guard_rsp_count");
      check("guard_rsp", rsp_at(1), rsp_exp(3'd0, 8'h13, 8'h19));
      run(10);

      // all four requesters valid right after reset, then 0 and 2 re-raised
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      clear_logs();
      stub_delay = 3;
      for (int i = 0; i < 4; i++) raise(i, 8'h01, 5'd0);
      wait_rsp(4, 200, "rr_first_four");
      raise(2, 8'h01, 5'd0);
      raise(0, 8'h01, 5'd0);
      wait_rsp(6, 200, "rr_all_six");
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rr_grant_%0d", k), grant_at(k), 32'(order[k]));
         check($sformatf("rr_rsp_%0d", k), rsp_at(k), rsp_exp(3'(order[k]), 8'h13, 8'h19));
      end
      run(10);

      // hung decoder: timeout after exactly 20 enabled cycles
      clear_logs();
      stub_delay = 0;
      raise(2, 8'h01, 5'd0);
      wait_rsp(1, 100, "timeout_rsp_count");
      check("timeout_enable_width", 32'(en_fall - en_rise), 32'd20);
      check("timeout_rsp", rsp_at(0), rsp_exp(3'd2, 8'hEF, 8'hEE));
      run(10);

      // out-of-range device: decoder untouched, next grant without GUARD
      clear_logs();
      stub_delay = 5;
      raise(3, 8'h01, 5'd3);
      wait_rsp(1, 50, "baddev_rsp_count");
      check("baddev_grant_id", grant_at(0), 32'd3);
      check("baddev_rsp", rsp_at(0), rsp_exp(3'd3, 8'hED, 8'hED));
      check("baddev_no_enable", 32'(en_seen), 32'd0);
      r = last_rsp_cyc;
      raise(1, 8'h01, 5'd0);
      wait_grant(2, 30, "baddev_next_count");
      check("baddev_next_gap", gcyc_at(1) - 32'(r), 32'd2);
      wait_rsp(2, 60, "baddev_next_rsp_count");
      check("baddev_next_rsp", rsp_at(1), rsp_exp(3'd1, 8'h13, 8'h19));
      run(10);

      // reset pulse in WAIT aborts the transaction silently
      clear_logs();
      stub_delay = 0;
      raise(0, 8'h01, 5'd0);
      begin
         int k = 0;
         while (!bus.dec_enable && k < 20) begin
            step();
            k++;
         end
      end
      check("abort_enable_rose", 32'(bus.dec_enable), 32'd1);
      run(2);
      reset = 1'b1;
      step();
      check("abort_enable_dropped", 32'(bus.dec_enable), 32'd0);
      reset = 1'b0;
      clear_logs();
      run(30);
      check("abort_no_rsp", 32'(rsp_log.size()), 32'd0);
      check("abort_enable_stays_low", 32'(en_seen), 32'd0);
      stub_delay = 4;
      raise(1, 8'h02, 5'd0);
      wait_rsp(1, 60, "after_abort_rsp_count");
      check("after_abort_grant", grant_at(0), 32'd1);
      check("after_abort_dec_request", 32'(req_at_rise), 32'h02);
      check("after_abort_rsp", rsp_at(0), rsp_exp(3'd1, 8'h13, 8'h19));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
